// File: rtl/systolic_ctrl.sv
// Sequencing controller for an N x N systolic MAC array: clear, skewed operand feed, flush, result hand-out.
// Optional cycle counter output when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl #(
    parameter int N        = 4,
    parameter int KW       = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              macc_clear,
    output logic [N-1:0]      a_rd_en,
    output logic [N*KW-1:0]   a_rd_addr,
    output logic [N-1:0]      b_rd_en,
    output logic [N*KW-1:0]   b_rd_addr,
    output logic [$clog2(N)-1:0] res_row,
    output logic              res_valid,
    input  logic              res_ready
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam int RW = $clog2(N);
    localparam int TW = KW + $clog2(2 * N);
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        OUT
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [KW-1:0]  k_q;
    logic [TW-1:0]  t_q;
    logic [FW-1:0]  f_q;
    logic [RW-1:0]  r_q;
    logic           done_q;

    logic [TW-1:0]  k_ext;
    logic [TW-1:0]  feed_len;
    logic           t_last;
    logic           start_ok;
    logic           handshake;
    logic           last_beat;

    // Feed length includes 2(N-1) extra cycles so the skew drains through the array.
    assign k_ext     = {{(TW-KW){1'b0}}, k_q};
    assign feed_len  = k_ext + TW'(2 * (N - 1));
    assign t_last    = (t_q == feed_len - TW'(1));
    assign start_ok  = (state_q == IDLE) && start && !abort;
    assign handshake = (state_q == OUT) && res_ready;
    assign last_beat = handshake && (r_q == RW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_ok) state_d = CLEAR;
                CLEAR:   state_d = (k_q == '0) ? OUT : FEED;
                FEED:    if (t_last) state_d = FLUSH;
                FLUSH:   if (f_q == FW'(PIPE_LAT - 1)) state_d = OUT;
                OUT:     if (last_beat) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            t_q    <= '0;
            f_q    <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
        end else begin
            if (start_ok) k_q <= k_len;
            t_q <= (state_q == FEED && state_d == FEED) ? t_q + TW'(1) : '0;
            f_q <= (state_q == FLUSH && state_d == FLUSH) ? f_q + FW'(1) : '0;
            if (state_d != OUT) begin
                r_q <= '0;
            end else if (handshake) begin
                r_q <= r_q + RW'(1);
            end
            done_q <= last_beat && !abort;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign macc_clear = (state_q == CLEAR);
    assign res_valid  = (state_q == OUT);
    assign res_row    = r_q;

    // Row i sees term k = t - i, giving the diagonal wavefront the array expects.
    always_comb begin
        a_rd_en   = '0;
        a_rd_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q == FEED && t_q >= TW'(i) && t_q < TW'(i) + k_ext) begin
                a_rd_en[i]            = 1'b1;
                a_rd_addr[i*KW +: KW] = KW'(t_q - TW'(i));
            end
        end
    end

    assign b_rd_en   = a_rd_en;
    assign b_rd_addr = a_rd_addr;

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (start_ok) begin
            cycle_count <= '0;
        end else if (busy && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (N=4, KW=8, PIPE_LAT=1).
module tb_systolic_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  k_len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        macc_clear;
    logic [3:0]  a_rd_en;
    logic [31:0] a_rd_addr;
    logic [3:0]  b_rd_en;
    logic [31:0] b_rd_addr;
    logic [1:0]  res_row;
    logic        res_valid;
    logic        res_ready;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] cycle_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    systolic_ctrl #(.N(4), .KW(8), .PIPE_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .macc_clear (macc_clear),
        .a_rd_en    (a_rd_en),
        .a_rd_addr  (a_rd_addr),
        .b_rd_en    (b_rd_en),
        .b_rd_addr  (b_rd_addr),
        .res_row    (res_row),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call lands just after a rising edge, so sampling here is the new cycle.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; k_len = '0; abort = 1'b0; res_ready = 1'b1;
        #12;
        compared++;
        if ({busy, done, macc_clear, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, res_row, res_valid} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b clr=%b aen=%h ben=%h valid=%b row=%0d exp all 0",
                     busy, done, macc_clear, a_rd_en, b_rd_en, res_valid, res_row);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        compared++;
        if (cycle_count !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_cycle_count got %0d exp 0", cycle_count);
        end
`endif
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic       e_en0, e_en3, e_val, e_busy;
        logic [7:0] e_a0;
        step;
        start = 1'b1; k_len = 8'd3; res_ready = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step;
            start = 1'b0;
            e_en0  = (c >= 2 && c <= 4);
            e_a0   = e_en0 ? 8'(c - 2) : 8'd0;
            e_en3  = (c >= 5 && c <= 7);
            e_val  = (c >= 12 && c <= 15);
            e_busy = (c >= 1 && c <= 15);
            compared++;
            if (macc_clear !== (c == 1)) begin
                mismatched++;
                $display("[TB] FAIL basic_clear c=%0d got %b exp %b", c, macc_clear, (c == 1));
            end
            compared++;
            if (a_rd_en[0] !== e_en0 || a_rd_addr[7:0] !== e_a0) begin
                mismatched++;
                $display("[TB] FAIL basic_row0 c=%0d got en=%b addr=%0d exp en=%b addr=%0d", c, a_rd_en[0], a_rd_addr[7:0], e_en0, e_a0);
            end
            compared++;
            if (a_rd_en[3] !== e_en3 || b_rd_en[3] !== e_en3) begin
                mismatched++;
                $display("[TB] FAIL basic_lane3 c=%0d got a=%b b=%b exp %b", c, a_rd_en[3], b_rd_en[3], e_en3);
            end
            compared++;
            if (res_valid !== e_val || (e_val && res_row !== 2'(c - 12))) begin
                mismatched++;
                $display("[TB] FAIL basic_result c=%0d got valid=%b row=%0d exp valid=%b row=%0d", c, res_valid, res_row, e_val, c - 12);
            end
            compared++;
            if (done !== (c == 16) || busy !== e_busy) begin
                mismatched++;
                $display("[TB] FAIL basic_done_busy c=%0d got done=%b busy=%b exp done=%b busy=%b", c, done, busy, (c == 16), e_busy);
            end
`ifdef SYSTOLIC_CTRL_PERF_EN
            if (c == 16) begin
                compared++;
                if (cycle_count !== 32'd15) begin
                    mismatched++;
                    $display("[TB] FAIL basic_cycle_count got %0d exp 15", cycle_count);
                end
            end
`endif
        end
    endtask

    task automatic test_backpressure;
        logic       e_val;
        logic [1:0] e_row;
        step;
        start = 1'b1; k_len = 8'd3; res_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step;
            start = 1'b0;
            res_ready = !(c >= 13 && c <= 15);
            e_val = (c >= 12 && c <= 18);
            e_row = (c == 12) ? 2'd0 : (c <= 16) ? 2'd1 : (c == 17) ? 2'd2 : 2'd3;
            compared++;
            if (res_valid !== e_val || (e_val && res_row !== e_row)) begin
                mismatched++;
                $display("[TB] FAIL bp_result c=%0d got valid=%b row=%0d exp valid=%b row=%0d", c, res_valid, res_row, e_val, e_row);
            end
            compared++;
            if (done !== (c == 19)) begin
                mismatched++;
                $display("[TB] FAIL bp_done c=%0d got %b exp %b", c, done, (c == 19));
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_k_zero;
        logic e_val;
        step;
        start = 1'b1; k_len = 8'd0;
        for (int c = 1; c <= 7; c++) begin
            step;
            start = 1'b0;
            e_val = (c >= 2 && c <= 5);
            compared++;
            if (a_rd_en !== 4'd0 || b_rd_en !== 4'd0) begin
                mismatched++;
                $display("[TB] FAIL kzero_enables c=%0d got a=%h b=%h exp 0", c, a_rd_en, b_rd_en);
            end
            compared++;
            if (macc_clear !== (c == 1) || res_valid !== e_val || (e_val && res_row !== 2'(c - 2))) begin
                mismatched++;
                $display("[TB] FAIL kzero_seq c=%0d got clr=%b valid=%b row=%0d exp clr=%b valid=%b row=%0d",
                         c, macc_clear, res_valid, res_row, (c == 1), e_val, c - 2);
            end
            compared++;
            if (done !== (c == 6)) begin
                mismatched++;
                $display("[TB] FAIL kzero_done c=%0d got %b exp %b", c, done, (c == 6));
            end
        end
    endtask

    task automatic test_abort;
        step;
        start = 1'b1; k_len = 8'd3;
        for (int c = 1; c <= 8; c++) begin
            step;
            start = 1'b0;
            abort = (c == 4);
            compared++;
            if (busy !== (c <= 4)) begin
                mismatched++;
                $display("[TB] FAIL abort_busy c=%0d got %b exp %b", c, busy, (c <= 4));
            end
            if (c >= 5) begin
                compared++;
                if (a_rd_en !== 4'd0 || b_rd_en !== 4'd0 || res_valid !== 1'b0 || done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL abort_idle c=%0d got aen=%h ben=%h valid=%b done=%b exp all 0", c, a_rd_en, b_rd_en, res_valid, done);
                end
            end
        end
        abort = 1'b1; start = 1'b1; k_len = 8'd3;
        for (int c = 1; c <= 2; c++) begin
            step;
            compared++;
            if (busy !== 1'b0 || macc_clear !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL abort_start_idle c=%0d got busy=%b clr=%b exp 0 0", c, busy, macc_clear);
            end
        end
        abort = 1'b0; start = 1'b0;
    endtask

    task automatic test_start_during_feed;
        logic e_en3, e_val;
        step;
        start = 1'b1; k_len = 8'd3;
        for (int c = 1; c <= 17; c++) begin
            step;
            start = (c == 3);
            k_len = (c == 3) ? 8'd7 : 8'd3;
            e_en3 = (c >= 5 && c <= 7);
            e_val = (c >= 12 && c <= 15);
            compared++;
            if (a_rd_en[3] !== e_en3 || (c == 7 && a_rd_addr[31:24] !== 8'd2)) begin
                mismatched++;
                $display("[TB] FAIL sdf_lane3 c=%0d got en=%b addr=%0d exp en=%b", c, a_rd_en[3], a_rd_addr[31:24], e_en3);
            end
            compared++;
            if (res_valid !== e_val || done !== (c == 16)) begin
                mismatched++;
                $display("[TB] FAIL sdf_tail c=%0d got valid=%b done=%b exp valid=%b done=%b", c, res_valid, done, e_val, (c == 16));
            end
        end
    endtask

    task automatic test_reset_mid_out;
        int first_en0, first_en3, last_en3, first_val, done_c;
        logic [7:0] last_a3;
        step;
        start = 1'b1; k_len = 8'd3;
        for (int c = 1; c <= 13; c++) begin
            step;
            start = 1'b0;
        end
        compared++;
        if (res_valid !== 1'b1 || res_row !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL rst_pre_out got valid=%b row=%0d exp 1 1", res_valid, res_row);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({busy, done, macc_clear, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, res_row, res_valid} !== '0) begin
            mismatched++;
            $display("[TB] FAIL rst_async got busy=%b valid=%b row=%0d aen=%h exp all 0", busy, res_valid, res_row, a_rd_en);
        end
        #3 rst_n = 1'b1;

        first_en0 = 0; first_en3 = 0; last_en3 = 0; first_val = 0; done_c = 0; last_a3 = '0;
        step;
        start = 1'b1; k_len = 8'd255;
        for (int c = 1; c <= 275; c++) begin
            step;
            start = 1'b0;
            if (a_rd_en[0] && first_en0 == 0) first_en0 = c;
            if (a_rd_en[3]) begin
                if (first_en3 == 0) first_en3 = c;
                last_en3 = c;
                last_a3  = a_rd_addr[31:24];
            end
            if (res_valid && first_val == 0) first_val = c;
            if (done && done_c == 0) begin
                done_c = c;
`ifdef SYSTOLIC_CTRL_PERF_EN
                compared++;
                if (cycle_count !== 32'd267) begin
                    mismatched++;
                    $display("[TB] FAIL long_cycle_count got %0d exp 267", cycle_count);
                end
`endif
            end
        end
        compared++;
        if (first_en0 != 2 || first_en3 != 5 || last_en3 != 259 || last_a3 !== 8'd254) begin
            mismatched++;
            $display("[TB] FAIL long_feed got en0@%0d en3@%0d..%0d addr=%0d exp 2 5..259 254", first_en0, first_en3, last_en3, last_a3);
        end
        compared++;
        if (first_val != 264 || done_c != 268) begin
            mismatched++;
            $display("[TB] FAIL long_out got valid@%0d done@%0d exp 264 268", first_val, done_c);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_k_zero;
        test_abort;
        test_start_during_feed;
        test_reset_mid_out;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
